seven_seg_scan_controller: RTL and testbench

//  Time-multiplexes NUM_DIGITS hex digits onto one shared 7-segment bus plus per-digit anode enables.

---
 rtl/seven_seg_scan_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_controller
//
// Time-multiplexes NUM_DIGITS hex digits onto one shared 7-segment bus plus
// per-digit anode enables. Each digit owns a slot of PRESCALE clocks: the first
// BLANK_CYCLES clocks keep every anode off (anti-ghosting), the rest light the
// digit. The displayed value only changes at a frame boundary, so a frame never
// shows a mix of old and new digits. Every output is registered.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When defined, a digit is kept dark in its DRIVE window if it and every
//   higher nibble of the displayed value are zero. Digit 0 is always lit.
//   Slot timing does not change.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   enable      in   1 = scan, 0 = display dark and scanner idle
//   load        in   1-cycle strobe, captures digits_in into the staging reg
//   digits_in   in   [4*NUM_DIGITS-1:0], nibble i = digit i (digit 0 rightmost)
//   an          out  [NUM_DIGITS-1:0] anode enables, one-hot when lit
//   seg         out  [6:0] segments, bit order {g,f,e,d,c,b,a}
//   frame_done  out  1-cycle pulse during the last cycle of a frame
// -----------------------------------------------------------------------------
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(PRESCALE);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(PRESCALE - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Sequencer state
  state_t           state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             wrap;

  // Value path
  logic [VAL_W-1:0] staging_q, staging_d;
  logic [VAL_W-1:0] display_q, display_d;
  logic             pending_q, pending_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q,  an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;

  logic [3:0]            cur_nib;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  dark;

  // ---------------------------------------------------------------------------
  // Next-state logic for the scanner.
  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        BLANK: begin
          // slot counter runs across the whole slot, blank gap included
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_END) begin
            state_d = DRIVE;
          end
        end
        DRIVE: begin
          if (cnt_q == SLOT_END) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Staging / display update. The pending value is applied at the frame wrap
  // while scanning, or on any cycle spent in IDLE. A load coinciding with the
  // wrap lets the older pending value through and keeps the new one pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    staging_d = load ? digits_in : staging_q;
    display_d = display_q;
    pending_d = pending_q;

    if (pending_q && (wrap || (state_q == IDLE))) begin
      display_d = staging_q;
      pending_d = 1'b0;
    end

    if (load) begin
      pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Computed from next-state values so the registered an/seg
  // change on the same edge as the state register.
  // ---------------------------------------------------------------------------
  assign cur_nib = display_d[{idx_d, 2'b00} +: 4];
  assign onehot  = NUM_DIGITS'(1) << idx_d;

`ifdef LEADING_ZERO_BLANK_EN
  logic [VAL_W-1:0] upper_d;
  // Nibbles idx and above; digit is dark when they are all zero (never digit 0).
  assign upper_d = display_d >> {idx_d, 2'b00};
  assign dark    = (idx_d != '0) && (upper_d == '0);
`else
  assign dark    = 1'b0;
`endif

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if ((state_d == DRIVE) && !dark) begin
      an_d  = (ACTIVE_LOW != 0) ? ~onehot : onehot;
      seg_d = (ACTIVE_LOW != 0) ? ~hex7(cur_nib) : hex7(cur_nib);
    end
  end

  // Registered pulse that covers the final DRIVE cycle of the last digit,
  // i.e. the cycle whose closing edge is the frame wrap.
  assign frame_done_d = (state_d == DRIVE) && (idx_d == LAST_IDX) &&
                        (cnt_d == SLOT_END);

  // ---------------------------------------------------------------------------
  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      staging_q    <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      staging_q    <= staging_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// -----------------------------------------------------------------------------
// Directed testbench for seven_seg_scan_controller with NUM_DIGITS=4,
// PRESCALE=8, BLANK_CYCLES=2, ACTIVE_LOW=1. Frame = 32 cycles; cycle c=1 is
// the first clock after the edge that leaves IDLE (or after the previous frame).
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int tests_run = 0;
  int tests_failed = 0;

  // Active-low segment codes, hand-inverted from the gfedcba table.
  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] ZERO_MASK = 4'b0001;
`else
  localparam logic [3:0] ZERO_MASK = 4'b1111;
`endif

  seven_seg_scan_controller #(
    .NUM_DIGITS  (4),
    .PRESCALE    (8),
    .BLANK_CYCLES(2),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .digits_in (digits_in),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected outputs for frame cycle c (1..32) showing value v; lit_mask marks
  // digits that are allowed to light in their DRIVE window.
  function automatic void exp_cycle(input int c, input logic [15:0] v,
                                    input logic [3:0] lit_mask,
                                    output logic [3:0] an_e,
                                    output logic [6:0] seg_e,
                                    output logic fd_e);
    int slot;
    int pos;
    logic [3:0] nib;
    slot  = (c - 1) / 8;
    pos   = (c - 1) % 8;
    nib   = v[slot*4 +: 4];
    an_e  = 4'hF;
    seg_e = 7'h7F;
    fd_e  = (c == 32);
    if (pos >= 2 && lit_mask[slot]) begin
      an_e  = ~(4'b0001 << slot);
      seg_e = seg_lut[nib];
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; load = 1'b0; digits_in = 16'h0;
    @(negedge clk);
    tests_run++;
    if (an !== 4'hF) begin
      tests_failed++; $display("FAIL reset_an: got %h want %h", an, 4'hF);
    end
    tests_run++;
    if (seg !== 7'h7F) begin
      tests_failed++; $display("FAIL reset_seg: got %h want %h", seg, 7'h7F);
    end
    tests_run++;
    if (frame_done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_fd: got %b want 0", frame_done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      tests_failed++; $display("FAIL idle_dark: got an=%h seg=%h want an=F seg=7F", an, seg);
    end
  endtask

  // Load 1234 in IDLE, enable, then check two full frames of 1234.
  task automatic test_scan();
    logic [3:0] a_e; logic [6:0] s_e; logic f_e;
    digits_in = 16'h1234; load = 1'b1;
    @(negedge clk);
    load = 1'b0; enable = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      exp_cycle(c, 16'h1234, 4'hF, a_e, s_e, f_e);
      tests_run++;
      if (an !== a_e || seg !== s_e || frame_done !== f_e) begin
        tests_failed++;
        $display("FAIL scan c=%0d: got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 c, an, seg, frame_done, a_e, s_e, f_e);
      end
    end
  endtask

  // Mid-frame load of ABCD: rest of frame keeps 1234, next frame shows ABCD.
  task automatic test_midframe_load();
    logic [3:0] a_e; logic [6:0] s_e; logic f_e;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      exp_cycle(c, 16'h1234, 4'hF, a_e, s_e, f_e);
      tests_run++;
      if (an !== a_e || seg !== s_e || frame_done !== f_e) begin
        tests_failed++;
        $display("FAIL midload_old c=%0d: got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 c, an, seg, frame_done, a_e, s_e, f_e);
      end
      if (c == 10) begin digits_in = 16'hABCD; load = 1'b1; end
      if (c == 11) load = 1'b0;
    end
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      exp_cycle(c, 16'hABCD, 4'hF, a_e, s_e, f_e);
      tests_run++;
      if (an !== a_e || seg !== s_e || frame_done !== f_e) begin
        tests_failed++;
        $display("FAIL midload_new c=%0d: got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 c, an, seg, frame_done, a_e, s_e, f_e);
      end
    end
  endtask

  // Drop enable during digit 2 DRIVE, then restart from digit 0 with ABCD.
  task automatic test_disable();
    logic [3:0] a_e; logic [6:0] s_e; logic f_e;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      exp_cycle(c, 16'hABCD, 4'hF, a_e, s_e, f_e);
      tests_run++;
      if (an !== a_e || seg !== s_e || frame_done !== f_e) begin
        tests_failed++;
        $display("FAIL pre_disable c=%0d: got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 c, an, seg, frame_done, a_e, s_e, f_e);
      end
    end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL disabled k=%0d: got an=%h seg=%h fd=%b want an=F seg=7F fd=0",
                 k, an, seg, frame_done);
      end
    end
    enable = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      exp_cycle(c, 16'hABCD, 4'hF, a_e, s_e, f_e);
      tests_run++;
      if (an !== a_e || seg !== s_e || frame_done !== f_e) begin
        tests_failed++;
        $display("FAIL reenable c=%0d: got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 c, an, seg, frame_done, a_e, s_e, f_e);
      end
    end
  endtask

  // 5678 pending, then 9EF0 loaded on the wrap cycle itself.
  task automatic test_wrap_load();
    logic [3:0] a_e; logic [6:0] s_e; logic f_e;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      exp_cycle(c, 16'hABCD, 4'hF, a_e, s_e, f_e);
      tests_run++;
      if (an !== a_e || seg !== s_e || frame_done !== f_e) begin
        tests_failed++;
        $display("FAIL wrap_f0 c=%0d: got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 c, an, seg, frame_done, a_e, s_e, f_e);
      end
      if (c == 5)  begin digits_in = 16'h5678; load = 1'b1; end
      if (c == 6)  load = 1'b0;
      if (c == 32) begin digits_in = 16'h9EF0; load = 1'b1; end
    end
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      exp_cycle(c, 16'h5678, 4'hF, a_e, s_e, f_e);
      tests_run++;
      if (an !== a_e || seg !== s_e || frame_done !== f_e) begin
        tests_failed++;
        $display("FAIL wrap_f1 c=%0d: got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 c, an, seg, frame_done, a_e, s_e, f_e);
      end
      if (c == 1) load = 1'b0;
    end
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      exp_cycle(c, 16'h9EF0, 4'hF, a_e, s_e, f_e);
      tests_run++;
      if (an !== a_e || seg !== s_e || frame_done !== f_e) begin
        tests_failed++;
        $display("FAIL wrap_f2 c=%0d: got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 c, an, seg, frame_done, a_e, s_e, f_e);
      end
    end
  endtask

  // rst asserted between edges during digit 0 DRIVE; outputs go dark at once
  // and the display value returns to zero.
  task automatic test_reset_async();
    logic [3:0] a_e; logic [6:0] s_e; logic f_e;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got an=%h seg=%h fd=%b want an=F seg=7F fd=0",
               an, seg, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      exp_cycle(c, 16'h0000, ZERO_MASK, a_e, s_e, f_e);
      tests_run++;
      if (an !== a_e || seg !== s_e || frame_done !== f_e) begin
        tests_failed++;
        $display("FAIL post_reset c=%0d: got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                 c, an, seg, frame_done, a_e, s_e, f_e);
      end
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_leading_zero();
    logic [3:0] a_e; logic [6:0] s_e; logic f_e;
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    logic [3:0]  masks [2] = '{4'b0011, 4'b0001};
    for (int t = 0; t < 2; t++) begin
      enable = 1'b0;
      repeat (2) @(negedge clk);
      digits_in = vals[t]; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      for (int c = 1; c <= 32; c++) begin
        @(negedge clk);
        exp_cycle(c, vals[t], masks[t], a_e, s_e, f_e);
        tests_run++;
        if (an !== a_e || seg !== s_e || frame_done !== f_e) begin
          tests_failed++;
          $display("FAIL lzb t=%0d c=%0d: got an=%h seg=%h fd=%b want an=%h seg=%h fd=%b",
                   t, c, an, seg, frame_done, a_e, s_e, f_e);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_disable();
    test_wrap_load();
    test_reset_async();
`ifdef LEADING_ZERO_BLANK_EN
    test_leading_zero();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
